// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder/loader.
// Holds the symbolic op codes accepted on the command port, the RV32I opcode
// and funct fields, the loader FSM states, the latched command payload and a
// signed-range helper used by the optional immediate range check.
package rv_enc_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;

  // Symbolic command ops
  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'd2;
  localparam logic [OP_W-1:0] OP_LW    = 4'd3;
  localparam logic [OP_W-1:0] OP_SW    = 4'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'd5;
  localparam logic [OP_W-1:0] OP_BLT   = 4'd6;
  localparam logic [OP_W-1:0] OP_JAL   = 4'd7;
  localparam logic [OP_W-1:0] OP_JALR  = 4'd8;
  localparam logic [OP_W-1:0] OP_AUIPC = 4'd9;

  // RV32I major opcodes
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 / funct7
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Loader FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Command payload latched on accept
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic             last;
  } cmd_t;

  // True when imm is the sign extension of its low 'bits' bits
  function automatic logic sext_fits(input logic [XLEN-1:0] imm, input int unsigned bits);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(imm) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Command and IMEM-write bus of the instruction loader.
//   cmd_*      : host command handshake (valid/ready) with op and fields
//   imem_*     : IMEM write strobe, word address and data
// master = host / memory side, slave = loader side.
interface inst_encoder_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [31:0]       cmd_imm;
  logic              cmd_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_field_pack.sv
// Combinational RV32I field packer.
//   op/rd/rs1/rs2/imm in -> word (encoded instruction), legal (op is one of the
//   ten supported), in_range (immediate representable in its format).
// Macro RANGE_CHECK_EN: when defined, in_range reflects the immediate checks;
// when undefined, in_range is constant 1 and immediates are truncated.
module inst_field_pack
  import rv_enc_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  word,
  output logic             legal,
  output logic             in_range
);

  // Instruction word assembly
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:   word = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_RTYPE};
      OP_SUB:   word = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_RTYPE};
      OP_ADDI:  word = {imm[11:0], rs1, F3_ADDI, rd, OPC_IMM};
      OP_LW:    word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
      OP_SW:    word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      OP_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
      OP_BLT:   word = {imm[12], imm[10:5], rs2, rs1, F3_BLT, imm[4:1], imm[11], OPC_BRANCH};
      OP_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      OP_JALR:  word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
      OP_AUIPC: word = {imm[31:12], rd, OPC_AUIPC};
      default:  legal = 1'b0;
    endcase
  end

`ifdef RANGE_CHECK_EN
  // Immediate must survive truncation to its encoding field
  always_comb begin
    in_range = 1'b1;
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_JALR: in_range = sext_fits(imm, 12);
      OP_BEQ, OP_BLT:                 in_range = sext_fits(imm, 13) && !imm[0];
      OP_JAL:                         in_range = sext_fits(imm, 21) && !imm[0];
      OP_AUIPC:                       in_range = (imm[11:0] == 12'd0);
      default:                        in_range = 1'b1;
    endcase
  end
`else
  assign in_range = 1'b1;
`endif

endmodule

// File: rtl/inst_encoder_loader.sv
// Symbolic-command to RV32I encoder that preloads programs into IMEM.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   bus (slave)      : cmd_valid/cmd_ready/cmd_op/rd/rs1/rs2/imm/last in,
//                      imem_we/imem_addr/imem_wdata out
//   restart          : leave DONE, rewind address to BASE, clear flags
//   count            : words written since reset/restart
//   done             : program loaded (last command or DEPTH reached)
//   err_op/err_full/err_range : sticky error flags
// Macro RANGE_CHECK_EN: enables immediate range checking (err_range);
// undefined, immediates are truncated and err_range stays 0.
// Each command takes three cycles: accept (IDLE), encode (ENC), write (WR).
module inst_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned BASE   = 0,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  inst_encoder_loader_if.slave bus,
  input  logic                 restart,
  output logic [ADDR_W:0]      count,
  output logic                 done,
  output logic                 err_op,
  output logic                 err_full,
  output logic                 err_range
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_op_q, err_op_d;
  logic              err_full_q, err_full_d;
  logic              err_range_q, err_range_d;

  logic              accept_c;
  logic [XLEN-1:0]   word_c;
  logic              legal_c;
  logic              in_range_c;

  // Encoder operates on the latched command
  inst_field_pack u_pack (
    .op       (cmd_q.op),
    .rd       (cmd_q.rd),
    .rs1      (cmd_q.rs1),
    .rs2      (cmd_q.rs2),
    .imm      (cmd_q.imm),
    .word     (word_c),
    .legal    (legal_c),
    .in_range (in_range_c)
  );

  assign accept_c = bus.cmd_valid & ready_q;

  // Next-state, counters and flags
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    count_d     = count_q;
    err_op_d    = err_op_q;
    err_full_d  = err_full_q;
    err_range_d = err_range_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cmd_d.op   = bus.cmd_op;
          cmd_d.rd   = bus.cmd_rd;
          cmd_d.rs1  = bus.cmd_rs1;
          cmd_d.rs2  = bus.cmd_rs2;
          cmd_d.imm  = bus.cmd_imm;
          cmd_d.last = bus.cmd_last;
          state_d    = S_ENC;
        end
      end
      S_ENC: begin
        wdata_d = word_c;
        if (!legal_c || !in_range_c) begin
          // Rejected command: flag it and skip the write
          err_op_d    = err_op_q | ~legal_c;
          err_range_d = err_range_q | (legal_c & ~in_range_c);
          state_d     = cmd_q.last ? S_DONE : S_IDLE;
        end else begin
          we_d    = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        count_d = count_q + CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (cmd_q.last || (count_d == DEPTH_C)) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (restart) begin
          state_d     = S_IDLE;
          addr_d      = BASE_A;
          count_d     = '0;
          err_op_d    = 1'b0;
          err_full_d  = 1'b0;
          err_range_d = 1'b0;
        end else if (bus.cmd_valid && (count_q == DEPTH_C)) begin
          // A command is waiting but IMEM is full
          err_full_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= BASE_A;
      count_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_op_q    <= 1'b0;
      err_full_q  <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_op_q    <= err_op_d;
      err_full_q  <= err_full_d;
      err_range_q <= err_range_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign done           = done_q;
  assign err_op         = err_op_q;
  assign err_full       = err_full_q;
  assign err_range      = err_range_q;

endmodule
